pipeline_reg_fifo: RTL and testbench

- Parametrised elastic pipeline buffer with valid/backpressure (bp) handshakes on both sides.
- Generalises the single-slot and double-slot pipeline registers to an arbitrary depth.
- Adds an optional zero-latency bypass (latch) mode, an occupancy count, an almost-full flag and a synchronous flush.
- Placed between pipeline stages wherever the scheduler needs more than two tokens of slack.

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/pipeline_wrap_ctr.sv | 41 ++++
 rtl/pipeline_reg_fifo.sv | 111 +++++++++++
 tb/tb_pipeline_reg_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared helpers for the pipeline buffer family.
//   clog2        : ceiling log2, used to size pointers and counters
//   count_width  : bits needed to hold an occupancy of 0..depth
//   ptr_width    : bits needed to address depth slots (at least 1)
//   is_xfer      : a token moves when valid is high and bp is low
package pipeline_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int count_width(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  function automatic logic is_xfer(input logic valid, input logic bp);
    return valid && !bp;
  endfunction

endpackage

// File: rtl/pipeline_wrap_ctr.sv
// Modulo-Depth pointer used for the read and write sides of the buffer.
//   clk, resetn : clock and asynchronous active-low reset
//   clr         : synchronous return to slot 0 (flush)
//   inc         : advance by one slot
//   ptr         : current slot index, 0..Depth-1
module pipeline_wrap_ctr
  import pipeline_pkg::*;
#(
  parameter int Depth = 4,
  localparam int PW = ptr_width(Depth)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_d;
  logic [PW-1:0] ptr_q;

  // Depth need not be a power of two, so the wrap is an explicit compare
  // against the last slot rather than relying on binary overflow.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      if (ptr_q == PW'(Depth - 1)) ptr_d = '0;
      else                         ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipeline_reg_fifo.sv
// Elastic pipeline buffer with valid/backpressure handshakes on both sides.
//   clk, resetn      : clock and asynchronous active-low reset
//   flush            : synchronous clear of all stored tokens
//   d, d_valid, d_bp : upstream token, its valid, and backpressure to it
//   q, q_valid, q_bp : downstream token, its valid, and backpressure from it
//   count            : number of stored tokens
//   almost_full      : registered count >= AlmostFull
module pipeline_reg_fifo
  import pipeline_pkg::*;
#(
  parameter int Width      = 8,
  parameter int Depth      = 4,
  parameter int Bypass     = 0,
  parameter int AlmostFull = Depth - 1,
  localparam int CW = count_width(Depth),
  localparam int PW = ptr_width(Depth)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic [Width-1:0] d,
  input  logic             d_valid,
  output logic             d_bp,
  output logic [Width-1:0] q,
  output logic             q_valid,
  input  logic             q_bp,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  logic [Width-1:0] mem_q [Depth];
  logic [CW-1:0]    count_d, count_q;
  logic             almost_full_d, almost_full_q;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             empty, full, bypass_active;
  logic             incoming, outgoing, pass_through, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(Depth));

  // Backpressure looks only at stored state and flush, so q_bp never
  // reaches d_bp combinationally; a full buffer refuses even while popping.
  assign d_bp = full || flush;

  assign bypass_active = (Bypass != 0) && empty;

  // With bypass and nothing stored, the upstream token is shown directly.
  always_comb begin
    q       = mem_q[rd_ptr];
    q_valid = !empty && !flush;
    if (bypass_active) begin
      q       = d;
      q_valid = d_valid && !flush;
    end
  end

  assign incoming     = is_xfer(d_valid, d_bp);
  assign outgoing     = is_xfer(q_valid, q_bp);
  assign pass_through = bypass_active && incoming && outgoing;
  assign push         = incoming && !pass_through;
  assign pop          = outgoing && !pass_through;

  // Occupancy and its almost-full flag are computed from the same next
  // value so the flag rises on the very edge the threshold is reached.
  always_comb begin
    count_d = count_q;
    if (flush)             count_d = '0;
    else if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    almost_full_d = (count_d >= CW'(AlmostFull));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Storage is deliberately left unreset; q is ignored while q_valid is low.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= d;
  end

  pipeline_wrap_ctr #(.Depth(Depth)) u_wr_ctr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (flush),
    .inc    (push),
    .ptr    (wr_ptr)
  );

  pipeline_wrap_ctr #(.Depth(Depth)) u_rd_ctr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (flush),
    .inc    (pop),
    .ptr    (rd_ptr)
  );

  assign count       = count_q;
  assign almost_full = almost_full_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (!resetn) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!resetn) !(pop && empty));
  a_count_bound:  assert property (@(posedge clk) disable iff (!resetn) count_q <= CW'(Depth));

endmodule

// File: tb/tb_pipeline_reg_fifo.sv
// Scoreboard bench for pipeline_reg_fifo.
//   dut_a : Width=8, Depth=4, Bypass=0, AlmostFull=3 (fill, stream, flush, reset)
//   dut_b : Width=8, Depth=3, Bypass=1, AlmostFull=2 (bypass and pointer wrap)
// Expected tokens are queued as stimulus is issued; a negedge monitor pops
// and compares whenever a DUT hands a token downstream.
module tb_pipeline_reg_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       flush_a, dv_a, dbp_a, qv_a, qbp_a, af_a;
  logic [7:0] d_a, q_a;
  logic [2:0] cnt_a;
  logic       flush_b, dv_b, dbp_b, qv_b, qbp_b, af_b;
  logic [7:0] d_b, q_b;
  logic [1:0] cnt_b;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  pipeline_reg_fifo #(.Width(8), .Depth(4), .Bypass(0), .AlmostFull(3)) dut_a (
    .clk(clk), .resetn(resetn), .flush(flush_a), .d(d_a), .d_valid(dv_a), .d_bp(dbp_a),
    .q(q_a), .q_valid(qv_a), .q_bp(qbp_a), .count(cnt_a), .almost_full(af_a)
  );

  pipeline_reg_fifo #(.Width(8), .Depth(3), .Bypass(1), .AlmostFull(2)) dut_b (
    .clk(clk), .resetn(resetn), .flush(flush_b), .d(d_b), .d_valid(dv_b), .d_bp(dbp_b),
    .q(q_b), .q_valid(qv_b), .q_bp(qbp_b), .count(cnt_b), .almost_full(af_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic dv, input logic [7:0] dd,
                               input logic qbp, input logic fl);
    if (!sel) begin
      dv_a = dv; d_a = dd; qbp_a = qbp; flush_a = fl;
    end else begin
      dv_b = dv; d_b = dd; qbp_b = qbp; flush_b = fl;
    end
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every downstream handshake must match the oldest queued token.
  always @(negedge clk) begin
    if (resetn) begin
      if (qv_a && !qbp_a) begin
        compared++;
        if (exp_a.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL sb_a_unexpected: got 0x%0h, expected no token", q_a);
        end else begin
          if (q_a !== exp_a[0]) begin
            mismatched++;
            $display("[TB] FAIL sb_a_data: got 0x%0h, expected 0x%0h", q_a, exp_a[0]);
          end
          void'(exp_a.pop_front());
        end
      end
      if (qv_b && !qbp_b) begin
        compared++;
        if (exp_b.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL sb_b_unexpected: got 0x%0h, expected no token", q_b);
        end else begin
          if (q_b !== exp_b[0]) begin
            mismatched++;
            $display("[TB] FAIL sb_b_data: got 0x%0h, expected 0x%0h", q_b, exp_b[0]);
          end
          void'(exp_b.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    applyStimulus(0, 0, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);
    repeat (2) cycle();

    // Reset state
    checkOutput("rst_cnt_a", 32'(cnt_a), 0);
    checkOutput("rst_qv_a",  32'(qv_a),  0);
    checkOutput("rst_dbp_a", 32'(dbp_a), 0);
    checkOutput("rst_af_a",  32'(af_a),  0);
    checkOutput("rst_cnt_b", 32'(cnt_b), 0);
    checkOutput("rst_qv_b",  32'(qv_b),  0);
    resetn = 1'b1;
    cycle();
    $display("[TB] fill to full with downstream stalled");

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 8'((i + 1) * 17), 1, 0);
      exp_a.push_back(8'((i + 1) * 17));
      cycle();
      checkOutput("fill_cnt", 32'(cnt_a), 32'(i + 1));
      checkOutput("fill_af",  32'(af_a),  32'(i >= 2));
      checkOutput("fill_dbp", 32'(dbp_a), 32'(i == 3));
    end
    applyStimulus(0, 1, 8'h55, 1, 0);
    checkOutput("full_dbp_held", 32'(dbp_a), 1);
    cycle();
    checkOutput("full_cnt_held", 32'(cnt_a), 4);
    checkOutput("full_q_head",   32'(q_a),   32'h11);
    applyStimulus(0, 0, 8'h00, 0, 0);
    repeat (4) cycle();
    checkOutput("drain_cnt", 32'(cnt_a), 0);
    checkOutput("drain_af",  32'(af_a),  0);
    checkOutput("drain_dbp", 32'(dbp_a), 0);

    $display("[TB] streaming 100 tokens");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1, 8'(i), 0, 0);
      exp_a.push_back(8'(i));
      cycle();
      checkOutput("stream_cnt", 32'(cnt_a), 1);
    end
    applyStimulus(0, 0, 8'h00, 0, 0);
    repeat (2) cycle();
    checkOutput("stream_end_cnt", 32'(cnt_a), 0);

    $display("[TB] bypass pass-through and capture");
    applyStimulus(1, 1, 8'hA5, 0, 0);
    checkOutput("byp_qv",  32'(qv_b),  1);
    checkOutput("byp_q",   32'(q_b),   32'hA5);
    checkOutput("byp_cnt", 32'(cnt_b), 0);
    exp_b.push_back(8'hA5);
    cycle();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("byp_pass_cnt", 32'(cnt_b), 0);
    checkOutput("byp_pass_qv",  32'(qv_b),  0);
    applyStimulus(1, 1, 8'hA5, 1, 0);
    exp_b.push_back(8'hA5);
    cycle();
    applyStimulus(1, 0, 8'h00, 1, 0);
    checkOutput("byp_hold_cnt", 32'(cnt_b), 1);
    checkOutput("byp_hold_q",   32'(q_b),   32'hA5);
    checkOutput("byp_hold_qv",  32'(qv_b),  1);
    applyStimulus(1, 0, 8'h00, 0, 0);
    cycle();
    checkOutput("byp_release_cnt", 32'(cnt_b), 0);

    $display("[TB] pointer wrap on depth 3");
    for (int c = 0; c < 14; c++) begin
      applyStimulus(1, (c % 2 == 0), 8'(8'h60 + c / 2), 1'((c / 2) % 2), 0);
      if (c % 2 == 0) begin
        checkOutput("wrap_dbp", 32'(dbp_b), 0);
        exp_b.push_back(8'(8'h60 + c / 2));
      end
      cycle();
    end
    applyStimulus(1, 0, 8'h00, 0, 0);
    repeat (3) cycle();
    checkOutput("wrap_end_cnt", 32'(cnt_b), 0);

    $display("[TB] flush with three stored tokens");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 8'(8'h31 + i), 1, 0);
      exp_a.push_back(8'(8'h31 + i));
      cycle();
    end
    checkOutput("preflush_cnt", 32'(cnt_a), 3);
    checkOutput("preflush_af",  32'(af_a),  1);
    applyStimulus(0, 1, 8'h99, 1, 1);
    checkOutput("flush_dbp", 32'(dbp_a), 1);
    checkOutput("flush_qv",  32'(qv_a),  0);
    exp_a.delete();
    cycle();
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("postflush_cnt", 32'(cnt_a), 0);
    checkOutput("postflush_qv",  32'(qv_a),  0);
    checkOutput("postflush_af",  32'(af_a),  0);
    applyStimulus(0, 1, 8'h77, 0, 0);
    exp_a.push_back(8'h77);
    cycle();
    applyStimulus(0, 0, 8'h00, 0, 0);
    cycle();
    checkOutput("postflush_drain_cnt", 32'(cnt_a), 0);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(0, 1, 8'h41, 1, 0);
    exp_a.push_back(8'h41);
    cycle();
    applyStimulus(0, 1, 8'h42, 1, 0);
    exp_a.push_back(8'h42);
    cycle();
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("prerst_cnt", 32'(cnt_a), 2);
    checkOutput("prerst_qv",  32'(qv_a),  1);
    resetn = 1'b0;
    #1;
    checkOutput("arst_qv",  32'(qv_a),  0);
    checkOutput("arst_dbp", 32'(dbp_a), 0);
    checkOutput("arst_af",  32'(af_a),  0);
    checkOutput("arst_cnt", 32'(cnt_a), 0);
    exp_a.delete();
    #1;
    resetn = 1'b1;
    cycle();
    applyStimulus(0, 1, 8'h43, 0, 0);
    exp_a.push_back(8'h43);
    cycle();
    applyStimulus(0, 0, 8'h00, 0, 0);
    cycle();
    checkOutput("postrst_cnt", 32'(cnt_a), 0);

    repeat (2) cycle();
    checkOutput("sb_a_leftover", 32'(exp_a.size()), 0);
    checkOutput("sb_b_leftover", 32'(exp_b.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
